// File: rtl/press_classifier_fsm.sv
// Classifies debounced button gestures into short, double and long presses.
// Emits one-cycle event pulses, a held level during long presses and a wrapping event count.
module press_classifier_fsm #(
  parameter int unsigned LONG_CYCLES = 8,
  parameter int unsigned DOUBLE_GAP  = 6,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             debounced,
  output logic             short_press,
  output logic             double_press,
  output logic             long_press,
  output logic             held,
  output logic [CNT_W-1:0] evt_count
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    GAP       = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_next;
  logic             r_d_q;
  logic             w_rise;
  logic             w_fall;
  logic             w_short;
  logic             w_double;
  logic             w_long;
  logic             w_held;
  logic             r_short;
  logic             r_double;
  logic             r_long;
  logic             r_held;
  logic [CNT_W-1:0] r_evt_count;

  assign w_rise = debounced & ~r_d_q;
  assign w_fall = ~debounced & r_d_q;

  // State, timer, edge-detect and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_d_q       <= 1'b0;
      r_short     <= 1'b0;
      r_double    <= 1'b0;
      r_long      <= 1'b0;
      r_held      <= 1'b0;
      r_evt_count <= '0;
    end else begin
      r_state  <= w_next;
      r_timer  <= w_timer_next;
      r_d_q    <= debounced;
      r_short  <= w_short;
      r_double <= w_double;
      r_long   <= w_long;
      r_held   <= w_held;
      if (w_short | w_double | w_long) begin
        r_evt_count <= r_evt_count + CNT_W'(1);
      end
    end
  end

  // Next-state and event decode; the timer restarts on every state change
  always_comb begin
    w_next       = r_state;
    w_timer_next = r_timer + CNT_W'(1);
    w_short      = 1'b0;
    w_double     = 1'b0;
    w_long       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_timer_next = '0;
        if (w_rise) begin
          w_next = PRESS1;
        end
      end
      PRESS1: begin
        if (w_fall) begin
          w_next       = GAP;
          w_timer_next = '0;
        end else if (r_timer == LONG_LAST) begin
          w_next       = LONG_HOLD;
          w_long       = 1'b1;
          w_timer_next = '0;
        end
      end
      GAP: begin
        // A rise coinciding with the timeout still counts as the second press
        if (w_rise) begin
          w_next       = PRESS2;
          w_timer_next = '0;
        end else if (r_timer == GAP_LAST) begin
          w_next       = IDLE;
          w_short      = 1'b1;
          w_timer_next = '0;
        end
      end
      PRESS2: begin
        if (w_fall) begin
          w_next       = IDLE;
          w_double     = 1'b1;
          w_timer_next = '0;
        end else if (r_timer == LONG_LAST) begin
          w_next       = LONG_HOLD;
          w_long       = 1'b1;
          w_timer_next = '0;
        end
      end
      LONG_HOLD: begin
        w_timer_next = '0;
        if (w_fall) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next       = IDLE;
        w_timer_next = '0;
      end
    endcase
    w_held = (w_next == LONG_HOLD);
  end

  assign short_press  = r_short;
  assign double_press = r_double;
  assign long_press   = r_long;
  assign held         = r_held;
  assign evt_count    = r_evt_count;

endmodule
